// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module load_store_unit #(
    parameter int MEM_DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  mem_op_q, mem_op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        op_illegal, misaligned, out_of_range;
    logic [4:0]  lane_shift;
    logic [31:0] rd_shifted, lane_mask, merged, extended;

    // Request screening works on the live inputs so the verdict is ready at the accepting edge.
    always_comb begin
        op_illegal = 1'b0;
        misaligned = 1'b0;
        if (is_store) begin
            op_illegal = mem_op[2] | (mem_op[1:0] == 2'b11);
        end else begin
            op_illegal = (mem_op[1:0] == 2'b11) | (mem_op[2:1] == 2'b11);
        end
        if (mem_op[1:0] == 2'b01) begin
            misaligned = addr[0];
        end else if (mem_op[1:0] == 2'b10) begin
            misaligned = (addr[1:0] != 2'b00);
        end
        out_of_range = ((addr[31:2] >> MEM_DEPTH_LOG2) != 30'd0);
    end

    // Halfword lanes are 2-byte aligned, so the byte shift serves both sizes.
    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        rd_shifted = mem_rdata >> lane_shift;
        lane_mask  = (mem_op_q[1:0] == 2'b00) ? (32'h0000_00FF << lane_shift)
                                              : (32'h0000_FFFF << lane_shift);
        merged     = (mem_rdata & ~lane_mask) | ((mem_wdata_q << lane_shift) & lane_mask);
        case (mem_op_q)
            3'b000:  extended = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  extended = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  extended = {24'd0, rd_shifted[7:0]};
            3'b101:  extended = {16'd0, rd_shifted[15:0]};
            default: extended = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        mem_op_d    = mem_op_q;
        addr_d      = addr_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    is_store_d  = is_store;
                    mem_op_d    = mem_op;
                    addr_d      = addr;
                    mem_wdata_d = wdata;
                    if (op_illegal || misaligned || out_of_range) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end else if (is_store && mem_op == 3'b010) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (is_store_q) begin
                    mem_wdata_d = merged;
                    state_d     = S_WR;
                end else begin
                    load_data_d = extended;
                    state_d     = S_DONE;
                end
            end
            S_WR: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                fault_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            mem_op_q    <= 3'b000;
            addr_q      <= 32'd0;
            mem_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            mem_op_q    <= mem_op_d;
            addr_q      <= addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign fault     = (state_q == S_DONE) & fault_q;
    assign mem_read  = (state_q == S_RD);
    assign mem_write = (state_q == S_WR);
    assign load_data = load_data_q;
    assign mem_addr  = (state_q != S_IDLE) ? {2'b00, addr_q[31:2]} : 32'd0;
    assign mem_wdata = (state_q != S_IDLE) ? mem_wdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        is_store;
    logic [2:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic [31:0] load_data;
    logic        fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_DEPTH_LOG2(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .is_store  (is_store),
        .mem_op    (mem_op),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .load_data (load_data),
        .fault     (fault),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
        if (mem_write) mem[mem_addr[7:0]] = mem_wdata;
    end

    typedef struct {
        logic [31:0] flt;
        logic [31:0] ld;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] idx;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          neg_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_total = 0;
    logic [31:0] exp_ld = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;
        if (!reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (mem_write) wr_total++;
            if (mem_read || mem_write) begin
                rd_cnt += int'(mem_read);
                wr_cnt += int'(mem_write);
                chk("strobe_has_request", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) chk("mem_addr", mem_addr, sb_q[0].idx);
            end
            if (done) begin
                chk("done_has_request", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("fault", 32'(fault), e.flt);
                    chk("load_data", load_data, e.ld);
                    chk("latency", 32'(neg_cnt - e.acc), 32'(e.lat));
                    chk("read_pulses", 32'(rd_cnt), 32'(e.rd));
                    chk("write_pulses", 32'(wr_cnt), 32'(e.wr));
                    chk("ready_in_done", 32'(ready), 32'd0);
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end else if (fault) begin
                chk("fault_without_done", 32'(fault), 32'd0);
            end
        end
    end

    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic flt, input logic [31:0] ld,
                         input int lat, input int rd, input int wr);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
        req = 1'b1;
        is_store = st;
        mem_op = op;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        if (!st && !flt) exp_ld = ld;
        e.flt = 32'(flt);
        e.ld  = exp_ld;
        e.lat = lat;
        e.rd  = rd;
        e.wr  = wr;
        e.idx = {2'b00, a[31:2]};
        e.acc = neg_cnt;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, "_load_data"}, load_data, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int wr_before;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[0]   = 32'h5566_7788;
        mem[1]   = 32'h8899_AABB;
        mem[255] = 32'h8000_0001;
        mem_rdata = 32'd0;
        reset = 1'b0;
        req = 1'b0;
        is_store = 1'b0;
        mem_op = 3'b000;
        addr = 32'd0;
        wdata = 32'd0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // st, op, addr, wdata, fault, load result, latency, reads, writes
        issue(1'b0, 3'b000, 32'h6,   32'h0,         1'b0, 32'hFFFF_FF99, 3, 1, 0);
        issue(1'b0, 3'b100, 32'h6,   32'h0,         1'b0, 32'h0000_0099, 3, 1, 0);
        issue(1'b0, 3'b001, 32'h4,   32'h0,         1'b0, 32'hFFFF_AABB, 3, 1, 0);
        issue(1'b0, 3'b101, 32'h6,   32'h0,         1'b0, 32'h0000_8899, 3, 1, 0);
        issue(1'b1, 3'b001, 32'h6,   32'hDEAD_1234, 1'b0, 32'h0,         4, 1, 1);
        issue(1'b0, 3'b010, 32'h4,   32'h0,         1'b0, 32'h1234_AABB, 3, 1, 0);
        issue(1'b0, 3'b000, 32'h7,   32'h0,         1'b0, 32'h0000_0012, 3, 1, 0);
        issue(1'b1, 3'b010, 32'h8,   32'hCAFE_F00D, 1'b0, 32'h0,         2, 0, 1);
        issue(1'b1, 3'b000, 32'h9,   32'h0000_0077, 1'b0, 32'h0,         4, 1, 1);
        issue(1'b0, 3'b010, 32'h8,   32'h0,         1'b0, 32'hCAFE_770D, 3, 1, 0);
        issue(1'b0, 3'b001, 32'hA,   32'h0,         1'b0, 32'hFFFF_CAFE, 3, 1, 0);
        issue(1'b0, 3'b010, 32'h3FC, 32'h0,         1'b0, 32'h8000_0001, 3, 1, 0);
        issue(1'b0, 3'b010, 32'h5,   32'h0,         1'b1, 32'h0,         1, 0, 0);
        issue(1'b0, 3'b001, 32'h3,   32'h0,         1'b1, 32'h0,         1, 0, 0);
        issue(1'b1, 3'b010, 32'h400, 32'h1111_1111, 1'b1, 32'h0,         1, 0, 0);
        issue(1'b0, 3'b011, 32'h0,   32'h0,         1'b1, 32'h0,         1, 0, 0);
        issue(1'b1, 3'b011, 32'h0,   32'h0,         1'b1, 32'h0,         1, 0, 0);
        issue(1'b1, 3'b100, 32'h0,   32'h0,         1'b1, 32'h0,         1, 0, 0);
        drain();
        chk("mem1_after_sh", mem[1], 32'h1234_AABB);
        chk("mem2_after_sb", mem[2], 32'hCAFE_770D);
        chk("mem255_unchanged", mem[255], 32'h8000_0001);

        // Abandon an sb while it sits in RD_WAIT.
        wr_before = wr_total;
        issue(1'b1, 3'b000, 32'h1, 32'h0000_003C, 1'b0, 32'h0, 4, 1, 1);
        @(posedge clk);
        #1;
        chk("abort_not_ready", 32'(ready), 32'd0);
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_write", 32'(wr_total), 32'(wr_before));
        chk("abort_mem0_intact", mem[0], 32'h5566_7788);
        exp_ld = 32'd0;
        issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h5566_7788, 3, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
